harris_frame_sequencer: RTL and testbench

Frame-level controller for the Harris corner pipeline. It reads one frame from a pixel memory in raster order, drives the detector's pixel/pixel_valid stream, and tags the returning harris_score stream with valid and coordinates. It also thresholds each tagged score and reports frame completion. It sits between the frame memory and the detector top, and is the only block that sequences the detector.

---
 rtl/harris_pkg.sv | 15 +
 rtl/harris_tag_delay.sv | 39 +++
 rtl/harris_frame_sequencer.sv | 174 +++++++++++++++++
 tb/tb_harris_frame_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harris_pkg.sv
// Shared types and constants for the Harris frame sequencer.
package harris_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam int WIN = 6;
    localparam int SCORE_W = 32;
    localparam int PIX_W = 8;

endpackage

// File: rtl/harris_tag_delay.sv
// Fixed-latency shift register carrying {valid, full, x, y}
// alongside the detector pipeline.
module harris_tag_delay #(
    parameter int LAT = 8,
    parameter int XW = 6,
    parameter int YW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid,
    input  logic          full,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic          late_valid,
    output logic          late_full,
    output logic [XW-1:0] late_x,
    output logic [YW-1:0] late_y
);

    localparam int W = 2 + XW + YW;

    logic [W-1:0] sr [LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= {valid, full, x, y};
            for (int i = 1; i < LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign {late_valid, late_full, late_x, late_y} = sr[LAT-1];

endmodule

// File: rtl/harris_frame_sequencer.sv
// Frame sequencer feeding the Harris detector and tagging its scores.
// Optional HARRIS_CORNER_COUNT_EN adds a saturating corner_count output.
module harris_frame_sequencer
    import harris_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIPE_LAT = 8,
    parameter int ADDR_W = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic signed [SCORE_W-1:0]  threshold,
    input  logic                       stall,
    output logic                       mem_rd,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [PIX_W-1:0]           mem_data,
    output logic [PIX_W-1:0]           pixel,
    output logic                       pixel_valid,
    input  logic signed [SCORE_W-1:0]  harris_score,
    output logic                       score_valid,
    output logic [$clog2(IMG_W)-1:0]   score_x,
    output logic [$clog2(IMG_H)-1:0]   score_y,
    output logic                       corner,
    output logic                       busy,
    output logic                       done
`ifdef HARRIS_CORNER_COUNT_EN
    ,
    output logic [15:0]                corner_count
`endif
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int DW = $clog2(PIPE_LAT + 2) + 1;
    localparam logic [DW-1:0] DRAIN_LEN = DW'(PIPE_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    state_t state;
    state_t state_n;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] drain_cnt;
    logic signed [SCORE_W-1:0] thr_q;

    logic accept;
    logic last_rd;
    logic full_now;

    logic [XW-1:0] px_x;
    logic [YW-1:0] px_y;
    logic px_full;

    logic late_valid;
    logic late_full;

    assign accept = (state == IDLE) && start;
    assign mem_rd = (state == READ) && !stall;
    assign last_rd = mem_rd && (mem_addr == LAST_ADDR);
    assign full_now = (int'(x) >= WIN - 1) && (int'(y) >= WIN - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = READ;
            READ:    if (last_rd) state_n = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LEN) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Raster address and coordinates advance only on issued reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr <= '0;
            x <= '0;
            y <= '0;
        end else if (accept) begin
            mem_addr <= '0;
            x <= '0;
            y <= '0;
        end else if (mem_rd) begin
            mem_addr <= last_rd ? '0 : mem_addr + 1'b1;
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
        end else begin
            drain_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_q <= '0;
        end else if (accept) begin
            thr_q <= threshold;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel <= '0;
            pixel_valid <= 1'b0;
            px_x <= '0;
            px_y <= '0;
            px_full <= 1'b0;
        end else begin
            pixel <= mem_data;
            pixel_valid <= mem_rd;
            px_x <= x;
            px_y <= y;
            px_full <= full_now;
        end
    end

    harris_tag_delay #(
        .LAT(PIPE_LAT),
        .XW (XW),
        .YW (YW)
    ) u_tag (
        .clk       (clk),
        .reset     (reset),
        .valid     (pixel_valid),
        .full      (px_full),
        .x         (px_x),
        .y         (px_y),
        .late_valid(late_valid),
        .late_full (late_full),
        .late_x    (score_x),
        .late_y    (score_y)
    );

    assign score_valid = late_valid && late_full;
    assign corner = score_valid && (harris_score > thr_q);
    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef HARRIS_CORNER_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            corner_count <= '0;
        end else if (accept) begin
            corner_count <= '0;
        end else if (corner && (corner_count != 16'hFFFF)) begin
            corner_count <= corner_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_harris_frame_sequencer.sv
// Directed bench for harris_frame_sequencer (8x8 frame, PIPE_LAT=4).
module tb_harris_frame_sequencer;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int PIPE_LAT = 4;
    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic signed [31:0] threshold = 32'sd0;
    logic mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0] mem_data = 8'd0;
    logic [7:0] pixel;
    logic pixel_valid;
    logic signed [31:0] harris_score;
    logic score_valid;
    logic [2:0] score_x;
    logic [2:0] score_y;
    logic corner;
    logic busy;
    logic done;
`ifdef HARRIS_CORNER_COUNT_EN
    logic [15:0] corner_count;
`endif

    int checks = 0;
    int failures = 0;

    int mode = 0;
    int beat_cnt = 0;

    // Run recorders
    int n_rd, first_rd, last_rd, rd_after_st3;
    int n_pv, pv_first, pv_last;
    int stall_rd, addr_lo, addr_hi;
    int n_beats, first_x, first_y, last_x, last_y, first_beat_c;
    int n_corner, bad_corner, post_rst_beats;
    int n_done, busy_fall, busy_end;
    int done_q[$];
    bit rst_zero;
    int cc_at_done, cc_at1, cc_end;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_addr[7:0];
    end

    always_comb begin
        harris_score = 32'sd0;
        case (mode)
            1: harris_score = beat_cnt[0] ? 32'sd101 : 32'sd100;
            2: harris_score = 32'sd200;
            default: ;
        endcase
    end

    harris_frame_sequencer #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .PIPE_LAT(PIPE_LAT),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .threshold   (threshold),
        .stall       (stall),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .harris_score(harris_score),
        .score_valid (score_valid),
        .score_x     (score_x),
        .score_y     (score_y),
        .corner      (corner),
        .busy        (busy),
        .done        (done)
`ifdef HARRIS_CORNER_COUNT_EN
        ,
        .corner_count(corner_count)
`endif
    );

    // Cycle 0 is the cycle start is first driven; inputs change 1ns
    // after each rising edge and outputs are sampled 4ns later.
    task automatic run(input int ncyc, input int s_lo, input int s_hi,
                       input int st1, input int st2, input int st3,
                       input int rst_at, input logic signed [31:0] thr_mid);
        n_rd = 0; first_rd = -1; last_rd = -1; rd_after_st3 = -1;
        n_pv = 0; pv_first = -1; pv_last = -1;
        stall_rd = 0; addr_lo = -1; addr_hi = -1;
        n_beats = 0; first_x = -1; first_y = -1;
        last_x = -1; last_y = -1; first_beat_c = -1;
        n_corner = 0; bad_corner = 0; post_rst_beats = 0;
        n_done = 0; busy_fall = -1; busy_end = -1;
        done_q.delete();
        rst_zero = 1'b0;
        cc_at_done = -1; cc_at1 = -1; cc_end = -1;
        beat_cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            start = (c == 0) || (c == st1) || (c == st2) || (c == st3);
            stall = (c >= s_lo) && (c <= s_hi);
            if (c == 2 && thr_mid != threshold) threshold = thr_mid;
            if (rst_at >= 0 && c == rst_at) reset = 1'b0;
            if (rst_at >= 0 && c == rst_at + 2) reset = 1'b1;
            #4;
            if (mem_rd) begin
                n_rd++;
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                if (st3 >= 0 && c > st3 && rd_after_st3 < 0)
                    rd_after_st3 = c;
            end
            if (pixel_valid) begin
                n_pv++;
                if (pv_first < 0) pv_first = c;
                pv_last = c;
            end
            if (c >= s_lo && c <= s_hi && mem_rd) stall_rd++;
            if (c == s_lo) addr_lo = int'(mem_addr);
            if (c == s_hi) addr_hi = int'(mem_addr);
            if (corner && !score_valid) bad_corner++;
            if (score_valid) begin
                if (n_beats == 0) begin
                    first_x = int'(score_x);
                    first_y = int'(score_y);
                    first_beat_c = c;
                end
                last_x = int'(score_x);
                last_y = int'(score_y);
                n_beats++;
                if (rst_at >= 0 && c > rst_at) post_rst_beats++;
                if (corner) n_corner++;
            end
            if (rst_at >= 0 && c == rst_at)
                rst_zero = !mem_rd && mem_addr == 0 && pixel == 0 &&
                           !pixel_valid && !score_valid && score_x == 0 &&
                           score_y == 0 && !corner && !busy && !done;
            if (done) begin
                n_done++;
                done_q.push_back(c);
            end
            if (n_done > 0 && busy_fall < 0 && !busy) busy_fall = c;
            if (c == ncyc - 1) busy_end = int'(busy);
`ifdef HARRIS_CORNER_COUNT_EN
            if (done) cc_at_done = int'(corner_count);
            if (c == 1) cc_at1 = int'(corner_count);
            if (c == ncyc - 1) cc_end = int'(corner_count);
`endif
            if (score_valid) beat_cnt++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_rd, mem_addr, pixel, pixel_valid} !== '0) begin
            failures++;
            $display("FAIL rst_mem got=%b/%0d/%0d/%b exp=0",
                     mem_rd, mem_addr, pixel, pixel_valid);
        end
        checks++;
        if ({score_valid, score_x, score_y, corner} !== '0) begin
            failures++;
            $display("FAIL rst_score got=%b/%0d/%0d/%b exp=0",
                     score_valid, score_x, score_y, corner);
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL rst_ctl busy/done got=%b%b exp=00", busy, done);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame;
        threshold = 32'sd0;
        mode = 0;
        run(80, -10, -10, -1, -1, -1, -1, 32'sd0);
        checks++;
        if (n_rd != 64 || first_rd != 1 || last_rd != 64) begin
            failures++;
            $display("FAIL frame_rd got n=%0d first=%0d last=%0d exp 64/1/64",
                     n_rd, first_rd, last_rd);
        end
        checks++;
        if (pv_first != 2 || n_pv != 64 || pv_last != 65) begin
            failures++;
            $display("FAIL frame_pv got first=%0d n=%0d last=%0d exp 2/64/65",
                     pv_first, n_pv, pv_last);
        end
        checks++;
        if (n_done != 1 || done_q.size() == 0 || done_q[0] != 71) begin
            failures++;
            $display("FAIL frame_done got n=%0d at=%0d exp 1 at 71",
                     n_done, done_q.size() ? done_q[0] : -1);
        end
        checks++;
        if (busy_fall != 72) begin
            failures++;
            $display("FAIL frame_busy_fall got=%0d exp=72", busy_fall);
        end
        checks++;
        if (n_beats != 9) begin
            failures++;
            $display("FAIL frame_beats got=%0d exp=9", n_beats);
        end
        checks++;
        if (first_x != 5 || first_y != 5 || first_beat_c != 51) begin
            failures++;
            $display("FAIL frame_first got=(%0d,%0d)@%0d exp=(5,5)@51",
                     first_x, first_y, first_beat_c);
        end
        checks++;
        if (last_x != 7 || last_y != 7) begin
            failures++;
            $display("FAIL frame_last got=(%0d,%0d) exp=(7,7)",
                     last_x, last_y);
        end
    endtask

    task automatic test_stall;
        threshold = 32'sd0;
        mode = 0;
        run(85, 10, 14, -1, -1, -1, -1, 32'sd0);
        checks++;
        if (stall_rd != 0 || addr_lo != 9 || addr_hi != 9) begin
            failures++;
            $display("FAIL stall_hold got rd=%0d a10=%0d a14=%0d exp 0/9/9",
                     stall_rd, addr_lo, addr_hi);
        end
        checks++;
        if (pv_last - pv_first + 1 - n_pv != 5 || n_pv != 64) begin
            failures++;
            $display("FAIL stall_bubbles got span=%0d n=%0d exp 69/64",
                     pv_last - pv_first + 1, n_pv);
        end
        checks++;
        if (n_done != 1 || done_q.size() == 0 || done_q[0] != 76) begin
            failures++;
            $display("FAIL stall_done got n=%0d at=%0d exp 1 at 76",
                     n_done, done_q.size() ? done_q[0] : -1);
        end
        checks++;
        if (n_beats != 9 || first_x != 5 || first_y != 5 ||
            last_x != 7 || last_y != 7 || first_beat_c != 56) begin
            failures++;
            $display("FAIL stall_tags got n=%0d (%0d,%0d)@%0d..(%0d,%0d)",
                     n_beats, first_x, first_y, first_beat_c, last_x, last_y);
        end
    endtask

    task automatic test_threshold;
        threshold = 32'sd100;
        mode = 1;
        run(80, -10, -10, -1, -1, -1, -1, 32'sd1000);
        checks++;
        if (n_corner != 4 || n_beats != 9) begin
            failures++;
            $display("FAIL thr_100 got corners=%0d beats=%0d exp 4/9",
                     n_corner, n_beats);
        end
        checks++;
        if (bad_corner != 0) begin
            failures++;
            $display("FAIL thr_no_valid got=%0d exp=0", bad_corner);
        end
        threshold = -32'sd1;
        mode = 0;
        run(80, -10, -10, -1, -1, -1, -1, -32'sd1);
        checks++;
        if (n_corner != 9) begin
            failures++;
            $display("FAIL thr_neg got corners=%0d exp=9", n_corner);
        end
        threshold = 32'sd0;
    endtask

    task automatic test_restart;
        mode = 0;
        run(150, -10, -10, 5, 71, 73, -1, 32'sd0);
        checks++;
        if (n_done != 2) begin
            failures++;
            $display("FAIL restart_ndone got=%0d exp=2", n_done);
        end
        checks++;
        if (done_q.size() < 2 || done_q[0] != 71 || done_q[1] != 144) begin
            failures++;
            $display("FAIL restart_done_at got=%0d,%0d exp=71,144",
                     done_q.size() > 0 ? done_q[0] : -1,
                     done_q.size() > 1 ? done_q[1] : -1);
        end
        checks++;
        if (rd_after_st3 != 74 || n_rd != 128) begin
            failures++;
            $display("FAIL restart_rd got first=%0d n=%0d exp 74/128",
                     rd_after_st3, n_rd);
        end
        checks++;
        if (n_beats != 18) begin
            failures++;
            $display("FAIL restart_beats got=%0d exp=18", n_beats);
        end
    endtask

    task automatic test_mid_reset;
        mode = 0;
        run(60, -10, -10, -1, -1, -1, 30, 32'sd0);
        checks++;
        if (!rst_zero) begin
            failures++;
            $display("FAIL midrst_outputs got=nonzero exp=all0");
        end
        checks++;
        if (post_rst_beats != 0 || n_done != 0) begin
            failures++;
            $display("FAIL midrst_quiet got beats=%0d done=%0d exp 0/0",
                     post_rst_beats, n_done);
        end
        checks++;
        if (busy_end != 0) begin
            failures++;
            $display("FAIL midrst_idle got busy=%0d exp=0", busy_end);
        end
        run(80, -10, -10, -1, -1, -1, -1, 32'sd0);
        checks++;
        if (n_beats != 9 || n_done != 1 || done_q[0] != 71) begin
            failures++;
            $display("FAIL midrst_fresh got beats=%0d done=%0d exp 9/1@71",
                     n_beats, n_done);
        end
    endtask

`ifdef HARRIS_CORNER_COUNT_EN
    task automatic test_corner_count;
        threshold = 32'sd0;
        mode = 2;
        run(80, -10, -10, -1, -1, -1, -1, 32'sd0);
        checks++;
        if (cc_at_done != 9 || cc_end != 9) begin
            failures++;
            $display("FAIL cc_done got=%0d end=%0d exp 9/9",
                     cc_at_done, cc_end);
        end
        run(10, -10, -10, -1, -1, -1, -1, 32'sd0);
        checks++;
        if (cc_at1 != 0) begin
            failures++;
            $display("FAIL cc_clear got=%0d exp=0", cc_at1);
        end
        repeat (80) @(posedge clk);
        #1;
        mode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_threshold();
        test_restart();
        test_mid_reset();
`ifdef HARRIS_CORNER_COUNT_EN
        test_corner_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
